// File: rtl/ahb_blockram_port.sv
// AHB-Lite slave front end driving the write port and registered read port of a byte-enable block RAM.
// Latency: writes have no wait state; read data arrives after 1 cycle, or 2 cycles on a read-after-write hazard to the same word.
// Backpressure: HREADYOUT drops for one cycle on a hazard stall and on the first cycle of an ERROR response.
module ahb_blockram_port #(
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic                      HREADY,
  input  logic [31:0]               HWDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_in,
  output logic [3:0]                ram_size_decode,
  output logic [31:0]               ram_wdata,
  output logic [MEM_ADDR_WIDTH-1:0] ram_addr_out,
  input  logic [31:0]               ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD       = 3'd2,
    S_RD_STALL = 3'd3,
    S_ERR1     = 3'd4,
    S_ERR2     = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                r_mask;

  logic [MEM_ADDR_WIDTH-1:0] w_haddr_word;
  logic                      w_accept;
  logic                      w_can_accept;
  logic                      w_take;
  logic                      w_hazard;
  logic                      w_err;
  logic [3:0]                w_mask;
  logic                      w_unused_bits;

  assign w_haddr_word = HADDR[MEM_ADDR_WIDTH+1:2];
  assign w_accept     = HSEL & HREADY & HTRANS[1];

  // RD_STALL and ERR1 always advance; a new address phase is only taken when a data phase can end.
  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_WR) ||
                        (r_state == S_RD)   || (r_state == S_ERR2);
  assign w_take       = w_accept & w_can_accept;

  // A read of the word being written this cycle would see pre-write RAM contents.
  assign w_hazard     = (r_state == S_WR) && !HWRITE && (w_haddr_word == r_addr);

  // Address bits above the RAM and the SEQ/NONSEQ distinction do not affect this port.
  assign w_unused_bits = ^{HADDR[31:MEM_ADDR_WIDTH+2], HTRANS[0]};

  // Write address is the latched word; the lane mask gates whether anything is written.
  assign ram_addr_in = r_addr;

  // Byte-lane mask and alignment check for the current address phase.
  always_comb begin
    w_mask = 4'b0000;
    w_err  = 1'b0;
    case (HSIZE)
      3'd0: begin
        w_mask = 4'b0001 << HADDR[1:0];
      end
      3'd1: begin
        w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        w_err  = HADDR[0];
      end
      3'd2: begin
        w_mask = 4'b1111;
        w_err  = |HADDR[1:0];
      end
      default: begin
        w_err  = 1'b1;
      end
    endcase
  end

  // Next-state selection for the data phase that follows the current edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RD_STALL: w_next = S_RD;
      S_ERR1:     w_next = S_ERR2;
      default: begin
        if (w_take) begin
          if (w_err) begin
            w_next = S_ERR1;
          end else if (HWRITE) begin
            w_next = S_WR;
          end else if (w_hazard) begin
            w_next = S_RD_STALL;
          end else begin
            w_next = S_RD;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
    endcase
  end

  // Bus response, RAM strobes and read address driven from the current state.
  always_comb begin
    HREADYOUT       = 1'b1;
    HRESP           = 1'b0;
    HRDATA          = 32'h0;
    ram_size_decode = 4'b0000;
    ram_wdata       = 32'h0;
    ram_addr_out    = w_haddr_word;
    case (r_state)
      S_WR: begin
        ram_size_decode = r_mask;
        ram_wdata       = HWDATA;
      end
      S_RD: begin
        HRDATA = ram_rdata;
      end
      S_RD_STALL: begin
        HREADYOUT    = 1'b0;
        ram_addr_out = r_addr;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: begin
        HRESP = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // State register; reset drops any write whose data phase is in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Address-phase fields captured only when a transfer is taken.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr <= '0;
      r_mask <= 4'b0000;
    end else if (w_take) begin
      r_addr <= w_haddr_word;
      r_mask <= w_mask;
    end
  end

endmodule

// File: tb/tb_ahb_blockram_port.sv
// Bench for ahb_blockram_port: directed AHB transfers against a behavioural byte-enable RAM.
// Expected responses are queued at issue time and popped by a monitor at each data-phase completion.
// HREADY follows HREADYOUT except when the bench forces another slave's stall.
module tb_ahb_blockram_port;

  localparam int AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] ram_addr_in;
  logic [3:0]    ram_size_decode;
  logic [31:0]   ram_wdata;
  logic [AW-1:0] ram_addr_out;
  logic [31:0]   ram_rdata;
  logic          hold;

  assign HREADY = HREADYOUT & ~hold;

  always #5 HCLK = ~HCLK;

  ahb_blockram_port #(.MEM_ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ram_addr_in(ram_addr_in), .ram_size_decode(ram_size_decode), .ram_wdata(ram_wdata),
    .ram_addr_out(ram_addr_out), .ram_rdata(ram_rdata)
  );

  // Behavioural RAM: byte-lane writes, registered read returning pre-write data on a same-edge collision.
  logic [31:0] mem [0:63];
  always @(posedge HCLK) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_size_decode[n]) mem[ram_addr_in[5:0]][8*n +: 8] <= ram_wdata[8*n +: 8];
    end
    ram_rdata <= mem[ram_addr_out[5:0]];
  end

  typedef struct {
    logic          rd;
    logic          err;
    int            waits;
    logic [3:0]    mask;
    logic [AW-1:0] waddr;
    logic [31:0]   data;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_strobes = 0;
  int   strobe_cycles = 0;
  logic [31:0] pend_wdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: ready never seen within bound (t=%0t)", name, $time);
  endtask

  // Monitor: tracks data phases from bus handshakes and checks each against the queue head.
  logic dp_active = 1'b0;
  int   dp_waits  = 0;
  exp_t mon_e;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_active = 1'b0;
      dp_waits  = 0;
    end else begin
      if (ram_size_decode != 4'b0000) strobe_cycles++;
      if (dp_active) begin
        if (expq.size() == 0) begin
          fail("unexpected_data_phase");
          dp_active = 1'b0;
        end else begin
          mon_e = expq[0];
          chk("hresp", {31'h0, HRESP}, {31'h0, mon_e.err});
          if (HREADY) begin
            void'(expq.pop_front());
            chk("wait_cycles", dp_waits, mon_e.waits);
            chk("lane_strobe", {28'h0, ram_size_decode}, {28'h0, mon_e.mask});
            if (mon_e.rd && !mon_e.err) chk("hrdata", HRDATA, mon_e.data);
            if (!mon_e.rd && !mon_e.err) begin
              chk("ram_addr_in", {18'h0, ram_addr_in}, {18'h0, mon_e.waddr});
              chk("ram_wdata", ram_wdata, mon_e.data);
            end
            dp_waits = 0;
          end else begin
            dp_waits++;
          end
        end
      end
      if (HREADY) dp_active = HSEL & HTRANS[1];
    end
  end

  // One address phase; HWDATA carries the previous write's data for its data phase.
  task automatic bus(input logic act, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic err,
                     input int waits, input logic [3:0] mask);
    exp_t e;
    int   n;
    logic rdy;
    HSEL   = act;
    HTRANS = act ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = addr;
    HSIZE  = size;
    HWDATA = pend_wdata;
    if (act) begin
      e.rd    = !wr;
      e.err   = err;
      e.waits = waits;
      e.mask  = mask;
      e.waddr = addr[AW+1:2];
      e.data  = wr ? wdata : exp_rd;
      expq.push_back(e);
      if (wr && !err) exp_strobes++;
    end
    n = 0;
    do begin
      @(negedge HCLK);
      rdy = HREADY;
      @(posedge HCLK);
      #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) fail("bus_timeout");
    pend_wdata = wdata;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b0, 0, 4'h0);
  endtask

  task automatic wr_t(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d, input logic [3:0] mask);
    bus(1'b1, 1'b1, addr, size, d, 32'h0, 1'b0, 0, mask);
  endtask

  task automatic rd_t(input logic [31:0] addr, input logic [31:0] exp, input int waits);
    bus(1'b1, 1'b0, addr, 3'd2, 32'h0, exp, 1'b0, waits, 4'h0);
  endtask

  task automatic er_t(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    bus(1'b1, wr, addr, size, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 4'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, {31'h0, HREADYOUT}, 32'h1);
    chk({tag, "_hresp"}, {31'h0, HRESP}, 32'h0);
    chk({tag, "_strobe"}, {28'h0, ram_size_decode}, 32'h0);
    chk({tag, "_hrdata"}, HRDATA, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    hold = 1'b0; HRESETn = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0; HSIZE = 3'd0; HWDATA = 32'h0;
    @(negedge HCLK);
    chk_reset_outputs("reset");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Word write then read with an idle cycle between.
    wr_t(32'h10, 3'd2, 32'hDEADBEEF, 4'b1111);
    idle();
    rd_t(32'h10, 32'hDEADBEEF, 0);
    idle();

    // Sub-word writes over a known word; the read lands on the pending half write, so it stalls once.
    wr_t(32'h10, 3'd2, 32'h11223344, 4'b1111);
    wr_t(32'h13, 3'd0, 32'hAA000000, 4'b1000);
    wr_t(32'h10, 3'd1, 32'h00005566, 4'b0011);
    rd_t(32'h10, 32'hAA225566, 1);
    idle();

    // Read-after-write hazard on the same word, then a neighbouring word with no stall.
    wr_t(32'h20, 3'd2, 32'h12345678, 4'b1111);
    rd_t(32'h20, 32'h12345678, 1);
    wr_t(32'h20, 3'd2, 32'h0BADF00D, 4'b1111);
    rd_t(32'h24, 32'h00000000, 0);
    rd_t(32'h20, 32'h0BADF00D, 0);
    idle();

    // Misaligned and illegal-size transfers respond ERROR and leave the RAM untouched.
    wr_t(32'h00, 3'd2, 32'h01020304, 4'b1111);
    er_t(1'b1, 32'h01, 3'd1);
    er_t(1'b0, 32'h02, 3'd2);
    er_t(1'b1, 32'h00, 3'd3);
    rd_t(32'h00, 32'h01020304, 0);
    idle();

    // Reset during a write data phase drops the write.
    wr_t(32'h30, 3'd2, 32'h55AA55AA, 4'b1111);
    idle();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h30; HSIZE = 3'd2; HWDATA = 32'h0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D;
    chk("abort_in_wr_strobe", {28'h0, ram_size_decode}, 32'hF);
    #2 HRESETn = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge HCLK);
    chk_reset_outputs("abort_hold");
    @(posedge HCLK); #3;
    HRESETn = 1'b1;
    pend_wdata = 32'h0;
    @(posedge HCLK); #1;
    rd_t(32'h30, 32'h55AA55AA, 0);
    idle();

    // Another slave holds HREADY low for three cycles while this one is selected.
    hold = 1'b1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h10; HSIZE = 3'd2; HWDATA = 32'h0;
    repeat (3) begin
      @(negedge HCLK);
      chk("hold_hrdata", HRDATA, 32'h0);
      chk("hold_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    end
    @(posedge HCLK); #1;
    hold = 1'b0;
    rd_t(32'h10, 32'hAA225566, 0);
    idle();

    repeat (3) @(posedge HCLK);
    #1;
    chk("queue_drained", expq.size(), 32'h0);
    chk("strobe_cycles", strobe_cycles, exp_strobes);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_blockram_port.md
Name: ahb_blockram_port

Overview:
- AHB-Lite slave front end that drives one port pair of the team's byte-enable block RAM.
- The RAM has a write port (addrIn, sizeDecode, dataIn) and a registered read port (addrOut, dataOut, one-cycle latency).
- Converts AHB address/data phases into RAM write strobes and read addresses, with zero wait states in the normal case.
- Sits on the Cortex-M0 AHB matrix, in front of the code/data RAM instances.

Parameters:
- MEM_ADDR_WIDTH, 14, RAM word-address width; the byte address space is 2**(MEM_ADDR_WIDTH+2).

Ports:
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; bits [MEM_ADDR_WIDTH+1:2] form the word address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  0=byte, 1=half, 2=word; other values are illegal.
- HWRITE  in  1  write when 1.
- HREADY  in  1  bus-wide ready; address phase is sampled only when high.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- ram_addr_in  out  MEM_ADDR_WIDTH  RAM write word address.
- ram_size_decode  out  4  RAM byte-lane write enables; bit n writes byte n.
- ram_wdata  out  32  RAM write data.
- ram_addr_out  out  MEM_ADDR_WIDTH  RAM read word address.
- ram_rdata  in  32  RAM registered read data.

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]. Only on accept are address, size, lane mask and direction latched.
- Lane mask from HSIZE/HADDR[1:0]:
  - byte: 1<<HADDR[1:0].
  - half: 4'b0011 if HADDR[1]=0, else 4'b1100.
  - word: 4'b1111.
- Misalignment: half with HADDR[0]=1, word with HADDR[1:0]!=0, or HSIZE>2 is an error transfer. No RAM write occurs.
- States:
  - IDLE: no data phase in progress.
  - WR: write data phase.
  - RD: read data phase.
  - RD_STALL: read data phase with a hazard wait.
  - ERR1, ERR2: error response cycles.
- Next state on accept (from IDLE, WR, RD, or ERR2):
  - error transfer -> ERR1.
  - write -> WR.
  - read -> RD, or RD_STALL if hazard.
- No accept -> IDLE.
- RD_STALL -> RD unconditionally.
- ERR1 -> ERR2 unconditionally.
- Outputs by state:
  - IDLE/WR/RD: HREADYOUT=1, HRESP=0.
  - RD_STALL: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Write path (combinational from state and latched fields):
  - In WR: ram_addr_in = latched word address, ram_size_decode = latched mask, ram_wdata = HWDATA. The RAM commits at the edge ending WR.
  - In every other state ram_size_decode = 0.
- Read path:
  - ram_addr_out = HADDR word bits during any cycle with no stall pending, so RAM data arrives in the read data phase.
  - In RD_STALL, ram_addr_out = latched read word address.
  - HRDATA = ram_rdata in RD, else 0.
- Hazard: a read accepted while in WR to the same word address as the pending write.
  - The RAM would return pre-write data, so the read enters RD_STALL.
  - The RAM re-reads the held address at the end of RD_STALL, after the write commits.
  - RD then returns the updated word.
- Read data latency: 1 cycle normal, 2 cycles on hazard. Writes have no wait state.
- Back-to-back writes to the same word: each WR cycle writes its own lanes; the last one wins per lane.
- HREADY low (another slave stalling) with HSEL high: nothing is latched and the current state still completes.
- Reset (asynchronous, any state): state=IDLE, latched fields cleared, HREADYOUT=1, HRESP=0, ram_size_decode=0, HRDATA=0. A write in progress is dropped, not committed.

Test Plan:
- Word write 0xDEADBEEF @0x10, then read @0x10 with IDLE between -> ram_size_decode=1111 for exactly one cycle; HRDATA=0xDEADBEEF; HREADYOUT never low.
- Byte write 0xAA @0x13 over a word of 0x11223344, then half write 0x5566 @0x10 -> masks 1000 then 0011; read @0x10 gives 0xAA225566.
- Write word 0x12345678 @0x20 immediately followed by read @0x20 -> one HREADYOUT=0 cycle; HRDATA=0x12345678, not the old value. Same sequence with read @0x24 -> no stall.
- Half write @0x01, word read @0x02, HSIZE=3 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); ram_size_decode stays 0; RAM contents unchanged.
- HRESETn pulsed low mid-WR of 0xCAFEF00D @0x30 -> ram_size_decode drops to 0 immediately; a later read @0x30 returns the prior value; all outputs at reset values during reset.
- HSEL=1, HTRANS=NONSEQ, HREADY=0 for 3 cycles, then HREADY=1 -> no state change until the HREADY=1 edge; the transfer then completes normally.
